scan_seq_ctrl: RTL and testbench

SCAN_SEQ_CTRL -- requirements
Module: scan_seq_ctrl

---
 rtl/scan_seq_pkg.sv | 15 +
 rtl/scan_shift_cnt.sv | 35 +++
 rtl/scan_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_scan_seq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
// Shared types and default chain geometry for the scan sequencing controller.
package scan_seq_pkg;

    localparam int L0_DEFAULT = 3;
    localparam int L1_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        UNLOAD,
        RESP
    } state_e;

endpackage

// File: rtl/scan_shift_cnt.sv
// Clearable up-counter that stops at N-1 and flags the terminal count.
module scan_shift_cnt #(
    parameter int N = 3,
    parameter int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == W'(N - 1));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !tc_o)
            cnt_d = cnt_q + W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/scan_seq_ctrl.sv
// Scan pattern sequencer: loads two chains serially, pulses one capture cycle,
// unloads both tails into a response register and holds it until consumed.
module scan_seq_ctrl
    import scan_seq_pkg::*;
#(
    parameter int L0 = L0_DEFAULT,
    parameter int L1 = L1_DEFAULT
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          pat_valid,
    output logic          pat_ready,
    input  logic [L0-1:0] pat_si0,
    input  logic [L1-1:0] pat_si1,
    output logic          test_en,
    output logic          test_si0,
    output logic          test_si1,
    output logic          ce0,
    output logic          ce1,
    input  logic          test_so0,
    input  logic          test_so1,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [L0-1:0] rsp_so0,
    output logic [L1-1:0] rsp_so1,
    output logic          busy
);

    localparam int N  = L0;
    localparam int CW = $clog2(N + 1);

    // NOTE: reset asserts asynchronously but releases only after two clean clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            rst_sync_q <= '0;
        else
            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    state_e        state_q, state_d;
    logic [L0-1:0] pat0_q, pat0_d, rsp0_q, rsp0_d;
    logic [L1-1:0] pat1_q, pat1_d, rsp1_q, rsp1_d;
    logic [CW-1:0] cnt;
    logic          cnt_tc;
    logic          load_ce1;

    scan_shift_cnt #(.N(N), .W(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_d != state_q),
        .en_i  (state_q == LOAD || state_q == UNLOAD),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    // The shorter chain is loaded during the last L1 cycles so both finish together.
    if (L1 == L0) begin : g_ce1_full
        assign load_ce1 = 1'b1;
    end else begin : g_ce1_late
        assign load_ce1 = (cnt >= CW'(N - L1));
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        pat0_d    = pat0_q;
        pat1_d    = pat1_q;
        rsp0_d    = rsp0_q;
        rsp1_d    = rsp1_q;
        pat_ready = 1'b0;
        rsp_valid = 1'b0;
        test_en   = 1'b1;
        ce0       = 1'b0;
        ce1       = 1'b0;
        test_si0  = 1'b0;
        test_si1  = 1'b0;

        case (state_q)
            IDLE: begin
                pat_ready = 1'b1;
                if (pat_valid) begin
                    pat0_d  = pat_si0;
                    pat1_d  = pat_si1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ce0      = 1'b1;
                ce1      = load_ce1;
                test_si0 = pat0_q[L0-1];
                pat0_d   = pat0_q << 1;
                if (load_ce1) begin
                    test_si1 = pat1_q[L1-1];
                    pat1_d   = pat1_q << 1;
                end
                if (cnt_tc)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                test_en = 1'b0;
                ce0     = 1'b1;
                ce1     = 1'b1;
                state_d = UNLOAD;
            end
            UNLOAD: begin
                ce0    = 1'b1;
                ce1    = (cnt < CW'(L1));
                rsp0_d = (rsp0_q << 1) | L0'(test_so0);
                if (cnt < CW'(L1))
                    rsp1_d = (rsp1_q << 1) | L1'(test_so1);
                if (cnt_tc)
                    state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat0_q  <= '0;
            pat1_q  <= '0;
            rsp0_q  <= '0;
            rsp1_q  <= '0;
        end else begin
            state_q <= state_d;
            pat0_q  <= pat0_d;
            pat1_q  <= pat1_d;
            rsp0_q  <= rsp0_d;
            rsp1_q  <= rsp1_d;
        end
    end

    assign rsp_so0 = rsp0_q;
    assign rsp_so1 = rsp1_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed bench for scan_seq_ctrl: a 3/2 instance and a 4/4 instance, each
// driving simple chain models whose capture stores the inverse of the chain.
module tb_scan_seq_ctrl;

    logic clk = 1'b0;
    logic rstb;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // Instance A: L0=3, L1=2
    logic       a_pat_valid, a_pat_ready, a_test_en, a_test_si0, a_test_si1;
    logic       a_ce0, a_ce1, a_test_so0, a_test_so1, a_rsp_valid, a_rsp_ready, a_busy;
    logic [2:0] a_pat_si0, a_rsp_so0, a_q0 = '0;
    logic [1:0] a_pat_si1, a_rsp_so1, a_q1 = '0;

    // Instance B: L0=L1=4
    logic       b_pat_valid, b_pat_ready, b_test_en, b_test_si0, b_test_si1;
    logic       b_ce0, b_ce1, b_test_so0, b_test_so1, b_rsp_valid, b_rsp_ready, b_busy;
    logic [3:0] b_pat_si0, b_rsp_so0, b_q0 = '0;
    logic [3:0] b_pat_si1, b_rsp_so1, b_q1 = '0;

    scan_seq_ctrl #(.L0(3), .L1(2)) dut_a (
        .clk(clk), .rstb(rstb), .pat_valid(a_pat_valid), .pat_ready(a_pat_ready),
        .pat_si0(a_pat_si0), .pat_si1(a_pat_si1), .test_en(a_test_en),
        .test_si0(a_test_si0), .test_si1(a_test_si1), .ce0(a_ce0), .ce1(a_ce1),
        .test_so0(a_test_so0), .test_so1(a_test_so1), .rsp_valid(a_rsp_valid),
        .rsp_ready(a_rsp_ready), .rsp_so0(a_rsp_so0), .rsp_so1(a_rsp_so1), .busy(a_busy)
    );

    scan_seq_ctrl #(.L0(4), .L1(4)) dut_b (
        .clk(clk), .rstb(rstb), .pat_valid(b_pat_valid), .pat_ready(b_pat_ready),
        .pat_si0(b_pat_si0), .pat_si1(b_pat_si1), .test_en(b_test_en),
        .test_si0(b_test_si0), .test_si1(b_test_si1), .ce0(b_ce0), .ce1(b_ce1),
        .test_so0(b_test_so0), .test_so1(b_test_so1), .rsp_valid(b_rsp_valid),
        .rsp_ready(b_rsp_ready), .rsp_so0(b_rsp_so0), .rsp_so1(b_rsp_so1), .busy(b_busy)
    );

    // Chain models: flop 0 is the head, shift when test_en=1, capture ~Q when test_en=0.
    always @(posedge clk) begin
        if (a_ce0) a_q0 <= a_test_en ? {a_q0[1:0], a_test_si0} : ~a_q0;
        if (a_ce1) a_q1 <= a_test_en ? {a_q1[0], a_test_si1} : ~a_q1;
        if (b_ce0) b_q0 <= b_test_en ? {b_q0[2:0], b_test_si0} : ~b_q0;
        if (b_ce1) b_q1 <= b_test_en ? {b_q1[2:0], b_test_si1} : ~b_q1;
    end

    assign a_test_so0 = a_q0[2];
    assign a_test_so1 = a_q1[1];
    assign b_test_so0 = b_q0[3];
    assign b_test_so1 = b_q1[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_pat_ready"}, a_pat_ready, 1);
        check({tag, "_rsp_valid"}, a_rsp_valid, 0);
        check({tag, "_busy"},      a_busy, 0);
        check({tag, "_ce0"},       a_ce0, 0);
        check({tag, "_ce1"},       a_ce1, 0);
        check({tag, "_test_en"},   a_test_en, 1);
        check({tag, "_si0"},       a_test_si0, 0);
        check({tag, "_si1"},       a_test_si1, 0);
        check({tag, "_rsp_so0"},   a_rsp_so0, 0);
        check({tag, "_rsp_so1"},   a_rsp_so1, 0);
    endtask

    // Counts negedges from the first LOAD cycle until rsp_valid, bounded.
    task automatic wait_rsp_a(input string tag);
        int cycles = 1;
        while (!a_rsp_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check(tag, cycles, 8);
    endtask

    logic exp_si0 [3] = '{1'b1, 1'b0, 1'b1};
    logic exp_ce1 [3] = '{1'b0, 1'b1, 1'b1};
    logic exp_si1 [3] = '{1'b0, 1'b1, 1'b0};
    logic exp_uce1[3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        rstb = 1'b0;
        a_pat_valid = 0; a_pat_si0 = '0; a_pat_si1 = '0; a_rsp_ready = 0;
        b_pat_valid = 0; b_pat_si0 = '0; b_pat_si1 = '0; b_rsp_ready = 0;

        repeat (2) @(negedge clk);
        check_reset_a("por");
        rstb = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_ready", a_pat_ready, 1);
        check("idle_busy", a_busy, 0);

        // Pattern 1: si0=101, si1=10
        a_pat_si0 = 3'b101; a_pat_si1 = 2'b10; a_pat_valid = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_pat_valid = 0;
            check("load_busy", a_busy, 1);
            check("load_pat_ready", a_pat_ready, 0);
            check("load_test_en", a_test_en, 1);
            check("load_ce0", a_ce0, 1);
            check("load_ce1", a_ce1, exp_ce1[k]);
            check("load_si0", a_test_si0, exp_si0[k]);
            check("load_si1", a_test_si1, exp_si1[k]);
        end
        @(negedge clk);
        check("cap_test_en", a_test_en, 0);
        check("cap_ce0", a_ce0, 1);
        check("cap_ce1", a_ce1, 1);
        check("cap_si0", a_test_si0, 0);
        check("cap_si1", a_test_si1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("unl_test_en", a_test_en, 1);
            check("unl_ce0", a_ce0, 1);
            check("unl_ce1", a_ce1, exp_uce1[k]);
            check("unl_si0", a_test_si0, 0);
            check("unl_si1", a_test_si1, 0);
            check("unl_rsp_valid", a_rsp_valid, 0);
        end
        @(negedge clk);
        check("rsp_valid_t8", a_rsp_valid, 1);
        check("rsp_so0", a_rsp_so0, 3'b010);
        check("rsp_so1", a_rsp_so1, 2'b01);

        // Hold the response with a new pattern already offered
        a_pat_si0 = 3'b011; a_pat_si1 = 2'b01; a_pat_valid = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_rsp_valid", a_rsp_valid, 1);
            check("hold_so0", a_rsp_so0, 3'b010);
            check("hold_so1", a_rsp_so1, 2'b01);
            check("hold_pat_ready", a_pat_ready, 0);
            check("hold_ce0", a_ce0, 0);
            check("hold_ce1", a_ce1, 0);
            check("hold_busy", a_busy, 1);
        end

        // Handshake with pat_valid still high: next transfer exactly one cycle later
        a_rsp_ready = 1;
        @(negedge clk);
        a_rsp_ready = 0;
        check("b2b_idle_rsp_valid", a_rsp_valid, 0);
        check("b2b_idle_ready", a_pat_ready, 1);
        check("b2b_idle_busy", a_busy, 0);
        @(negedge clk);
        a_pat_valid = 0;
        check("b2b_load_busy", a_busy, 1);
        check("b2b_load_ce0", a_ce0, 1);
        check("b2b_load_si0", a_test_si0, 0);
        wait_rsp_a("b2b_latency");
        check("b2b_so0", a_rsp_so0, 3'b100);
        check("b2b_so1", a_rsp_so1, 2'b10);
        a_rsp_ready = 1;
        @(negedge clk);
        a_rsp_ready = 0;
        check("b2b_done_busy", a_busy, 0);

        // Reset asserted in LOAD cycle 1
        a_pat_si0 = 3'b110; a_pat_si1 = 2'b11; a_pat_valid = 1;
        @(negedge clk);
        a_pat_valid = 0;
        @(negedge clk);
        check("mid_busy", a_busy, 1);
        check("mid_si0", a_test_si0, 1);
        rstb = 1'b0;
        #1;
        check_reset_a("midload");
        @(negedge clk);
        rstb = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_ready", a_pat_ready, 1);
        a_pat_valid = 1;
        @(negedge clk);
        a_pat_valid = 0;
        wait_rsp_a("post_rst_latency");
        check("post_rst_so0", a_rsp_so0, 3'b001);
        check("post_rst_so1", a_rsp_so1, 2'b00);
        a_rsp_ready = 1;
        @(negedge clk);
        a_rsp_ready = 0;

        // Equal-length chains: ce1 follows ce0 through LOAD, CAPTURE, UNLOAD
        b_pat_si0 = 4'b1100; b_pat_si1 = 4'b0110; b_pat_valid = 1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            b_pat_valid = 0;
            check("b_ce0", b_ce0, 1);
            check("b_ce1", b_ce1, 1);
            check("b_test_en", b_test_en, (k == 4) ? 1'b0 : 1'b1);
        end
        @(negedge clk);
        check("b_rsp_valid", b_rsp_valid, 1);
        check("b_so0", b_rsp_so0, 4'b0011);
        check("b_so1", b_rsp_so1, 4'b1001);
        b_rsp_ready = 1;
        @(negedge clk);
        b_rsp_ready = 0;
        check("b_done_busy", b_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
